// File: rtl/rr_arb_ctrl_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arb_ctrl_bridge
//  Purpose  : Round-robin arbiter/controller sharing one bridge target port
//             between N_MASTER requesters. It drives the select of a fan-in
//             request mux tree and exports the priority pointer as per-level
//             RR flags. Once a selection is stalled by the target, it is
//             locked and held until the target grants it.
//  Ports    : clk        - clock, all state on rising edge
//             rst        - synchronous active-high reset
//             req_i      - per-master request
//             gnt_o      - per-master grant (one-hot or zero)
//             req_o      - request to target port
//             gnt_i      - grant from target port
//             sel_o      - index of master routed to the target
//             rr_flag_o  - round-robin pointer; bit k feeds tree level k
//             locked_o   - high while a stalled selection is held
//  Params   : N_MASTER must be a power of two and >= 2 so that pointer
//             arithmetic wraps naturally in LOG_MASTER bits.
//  Revision : 1.0 - initial release
// ============================================================================
module rr_arb_ctrl_bridge #(
    parameter int N_MASTER   = 4,
    parameter int LOG_MASTER = $clog2(N_MASTER)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_MASTER-1:0]   req_i,
    output logic [N_MASTER-1:0]   gnt_o,
    output logic                  req_o,
    input  logic                  gnt_i,
    output logic [LOG_MASTER-1:0] sel_o,
    output logic [LOG_MASTER-1:0] rr_flag_o,
    output logic                  locked_o
);

    localparam logic [LOG_MASTER-1:0] c_one = LOG_MASTER'(1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [LOG_MASTER-1:0] r_rr;
    logic [LOG_MASTER-1:0] w_rr_nxt;
    logic [LOG_MASTER-1:0] r_lock_idx;
    logic [LOG_MASTER-1:0] w_lock_idx_nxt;

    logic [LOG_MASTER-1:0] w_winner;
    logic [LOG_MASTER-1:0] w_cand;
    logic                  w_found;
    logic                  w_any_req;

    logic [LOG_MASTER-1:0] w_sel;
    logic                  w_req;
    logic [N_MASTER-1:0]   w_gnt;

    assign w_any_req = |req_i;

    // ------------------------------------------------------------------------
    // Winner search: scan from the pointer upward, wrapping modulo N_MASTER.
    // The candidate index wraps for free because N_MASTER is a power of two.
    // With no request the pointer itself is reported, keeping sel stable.
    // ------------------------------------------------------------------------
    always_comb begin
        w_winner = r_rr;
        w_found  = 1'b0;
        w_cand   = r_rr;
        for (int k = 0; k < N_MASTER; k++) begin
            w_cand = r_rr + LOG_MASTER'(k);
            if (!w_found && req_i[w_cand]) begin
                w_winner = w_cand;
                w_found  = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_rr       <= '0;
            r_lock_idx <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_rr       <= w_rr_nxt;
            r_lock_idx <= w_lock_idx_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and output decode
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt    = r_state;
        w_rr_nxt       = r_rr;
        w_lock_idx_nxt = r_lock_idx;
        w_sel          = w_winner;
        w_req          = 1'b0;
        w_gnt          = '0;

        case (r_state)
            ST_IDLE: begin
                w_sel = w_winner;
                w_req = w_any_req;
                if (w_req && gnt_i) begin
                    // Zero-latency handshake; pointer moves past the winner.
                    w_gnt[w_winner] = 1'b1;
                    w_rr_nxt        = w_winner + c_one;
                end else if (w_req) begin
                    // Target stalled: freeze this selection until granted.
                    w_state_nxt    = ST_LOCK;
                    w_lock_idx_nxt = w_winner;
                end
            end

            ST_LOCK: begin
                // Only the locked master is considered, whatever its priority.
                w_sel = r_lock_idx;
                w_req = req_i[r_lock_idx];
                if (w_req && gnt_i) begin
                    w_gnt[r_lock_idx] = 1'b1;
                    w_rr_nxt          = r_lock_idx + c_one;
                    w_state_nxt       = ST_IDLE;
                end else if (!w_req) begin
                    // Locked master withdrew its request: release without
                    // moving the pointer so nobody loses its turn.
                    w_state_nxt = ST_IDLE;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Reset suppresses any transfer in the same cycle.
    assign req_o     = w_req & ~rst;
    assign gnt_o     = rst ? '0 : w_gnt;
    assign sel_o     = w_sel;
    assign rr_flag_o = r_rr;
    assign locked_o  = (r_state == ST_LOCK);

endmodule
`default_nettype wire
